// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared types for the I3C format FIFO (entry layout and width).
// Rev    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam int FMT_FIFO_WIDTH = 13;

  // Field order mirrors the wdata_i bit order; "byte" is a keyword, hence fmt_byte.
  typedef struct packed {
    logic       nak_ok;
    logic       read_continue;
    logic       read_bytes;
    logic       stop_after;
    logic       start_before;
    logic [7:0] fmt_byte;
  } fmt_entry_t;

endpackage
`default_nettype wire

// File: rtl/i3c_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : i3c_sync_fifo
// Brief  : Generic first-word-fall-through ring buffer with occupancy count.
// Rev    : 1.0 - initial release
// ============================================================================
module i3c_sync_fifo #(
  parameter  int Width      = 13,
  parameter  int Depth      = 64,
  localparam int DepthWidth = $clog2(Depth + 1),
  localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [Width-1:0]      wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [Width-1:0]      rdata_o,
  output logic [DepthWidth-1:0] depth_o
);

  localparam logic [PtrWidth-1:0]   c_last_ptr = PtrWidth'(Depth - 1);
  localparam logic [DepthWidth-1:0] c_full     = DepthWidth'(Depth);

  logic [Width-1:0]      r_mem [Depth];
  logic [PtrWidth-1:0]   r_wptr;
  logic [PtrWidth-1:0]   r_rptr;
  logic [DepthWidth-1:0] r_depth;
  logic                  w_push;
  logic                  w_pop;

  assign wready_o = (r_depth != c_full);
  assign rvalid_o = (r_depth != '0);
  assign w_push   = wvalid_i & wready_o;
  assign w_pop    = rvalid_o & rready_i;
  assign rdata_o  = r_mem[r_rptr];
  assign depth_o  = r_depth;

  // Depth need not be a power of two, so wrap on an explicit compare.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_depth <= '0;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_depth <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_depth <= r_depth + 1'b1;
        2'b01:   r_depth <= r_depth - 1'b1;
        default: r_depth <= r_depth;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) r_mem[r_wptr] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/i3c_fmt_fifo.sv
`default_nettype none
// ============================================================================
// Module : i3c_fmt_fifo
// Brief  : Host-mode command format FIFO with threshold and overflow events.
// Rev    : 1.0 - initial release
// ============================================================================
module i3c_fmt_fifo
  import i2c_pkg::*;
#(
  parameter  int FifoDepth      = 64,
  localparam int FifoDepthWidth = $clog2(FifoDepth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  input  logic [FMT_FIFO_WIDTH-1:0] wdata_i,
  output logic                      fmt_fifo_rvalid_o,
  input  logic                      fmt_fifo_rready_i,
  output logic [FifoDepthWidth-1:0] fmt_fifo_depth_o,
  output logic [7:0]                fmt_byte_o,
  output logic                      fmt_flag_start_before_o,
  output logic                      fmt_flag_stop_after_o,
  output logic                      fmt_flag_read_bytes_o,
  output logic                      fmt_flag_read_continue_o,
  output logic                      fmt_flag_nak_ok_o,
  input  logic [FifoDepthWidth-1:0] fmt_threshold_i,
  output logic                      event_fmt_threshold_o,
  output logic                      event_fmt_overflow_o
);

  fmt_entry_t                w_head;
  logic                      w_wready;
  logic [FifoDepthWidth-1:0] w_depth;
  logic                      r_overflow;

  i3c_sync_fifo #(
    .Width (FMT_FIFO_WIDTH),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clear_i),
    .wvalid_i (wvalid_i),
    .wready_o (w_wready),
    .wdata_i  (wdata_i),
    .rvalid_o (fmt_fifo_rvalid_o),
    .rready_i (fmt_fifo_rready_i),
    .rdata_o  (w_head),
    .depth_o  (w_depth)
  );

  assign wready_o                 = w_wready;
  assign fmt_fifo_depth_o         = w_depth;
  assign fmt_byte_o               = w_head.fmt_byte;
  assign fmt_flag_start_before_o  = w_head.start_before;
  assign fmt_flag_stop_after_o    = w_head.stop_after;
  assign fmt_flag_read_bytes_o    = w_head.read_bytes;
  assign fmt_flag_read_continue_o = w_head.read_continue;
  assign fmt_flag_nak_ok_o        = w_head.nak_ok;
  assign event_fmt_threshold_o    = (w_depth < fmt_threshold_i);
  assign event_fmt_overflow_o     = r_overflow;

  // A flush drops the colliding write, so it must not be reported as overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_overflow <= 1'b0;
    else       r_overflow <= wvalid_i & ~w_wready & ~clear_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_i3c_fmt_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_i3c_fmt_fifo
// Brief  : Directed self-checking bench for the I3C format FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_i3c_fmt_fifo;

  localparam int DEPTH = 64;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_i = 1'b0;
  logic          wvalid_i = 1'b0;
  logic          wready_o;
  logic [12:0]   wdata_i = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] depth;
  logic [7:0]    fbyte;
  logic          f_start, f_stop, f_rb, f_rc, f_nak;
  logic [DW-1:0] thr = '0;
  logic          ev_thr, ev_ovf;

  int checks   = 0;
  int failures = 0;

  i3c_fmt_fifo #(.FifoDepth(DEPTH)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .clear_i                  (clear_i),
    .wvalid_i                 (wvalid_i),
    .wready_o                 (wready_o),
    .wdata_i                  (wdata_i),
    .fmt_fifo_rvalid_o        (rvalid),
    .fmt_fifo_rready_i        (rready),
    .fmt_fifo_depth_o         (depth),
    .fmt_byte_o               (fbyte),
    .fmt_flag_start_before_o  (f_start),
    .fmt_flag_stop_after_o    (f_stop),
    .fmt_flag_read_bytes_o    (f_rb),
    .fmt_flag_read_continue_o (f_rc),
    .fmt_flag_nak_ok_o        (f_nak),
    .fmt_threshold_i          (thr),
    .event_fmt_threshold_o    (ev_thr),
    .event_fmt_overflow_o     (ev_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    wvalid_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      wdata_i = 13'(base + i);
      tick();
    end
    wvalid_i = 1'b0;
  endtask

  function automatic logic [12:0] head();
    return {f_nak, f_rc, f_rb, f_stop, f_start, fbyte};
  endfunction

  initial begin
    // Reset state
    #1;
    chk("rst_wready", 32'(wready_o), 1);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_ovf", 32'(ev_ovf), 0);
    chk("rst_thr0", 32'(ev_thr), 0);
    thr = 7'd1;
    #1;
    chk("rst_thr1", 32'(ev_thr), 1);
    tick();
    rst = 1'b0;
    tick();

    // Three entries, depth counts up, rvalid one cycle after first write
    wvalid_i = 1'b1;
    wdata_i  = 13'h1A5;
    #1;
    chk("t1_rvalid_before", 32'(rvalid), 0);
    tick();
    chk("t1_depth1", 32'(depth), 1);
    chk("t1_rvalid1", 32'(rvalid), 1);
    wdata_i = 13'h03C;
    tick();
    chk("t1_depth2", 32'(depth), 2);
    wdata_i = 13'h27E;
    tick();
    chk("t1_depth3", 32'(depth), 3);
    wvalid_i = 1'b0;
    chk("t1_head0", 32'(head()), 32'h1A5);
    rready = 1'b1;
    tick();
    chk("t1_head1", 32'(head()), 32'h03C);
    chk("t1_depth_pop1", 32'(depth), 2);
    tick();
    chk("t1_head2", 32'(head()), 32'h27E);
    tick();
    chk("t1_depth_empty", 32'(depth), 0);
    chk("t1_rvalid_empty", 32'(rvalid), 0);
    // Underflow attempt is ignored
    tick();
    chk("t1_underflow_depth", 32'(depth), 0);
    chk("t1_underflow_ovf", 32'(ev_ovf), 0);
    rready = 1'b0;

    // Threshold 4 with depth 0 -> 5 -> 0
    thr = 7'd4;
    #1;
    chk("thr_d0", 32'(ev_thr), 1);
    wvalid_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wdata_i = 13'(i);
      tick();
      chk($sformatf("thr_up_d%0d", i), 32'(ev_thr), (i < 4) ? 1 : 0);
    end
    wvalid_i = 1'b0;
    rready   = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk($sformatf("thr_dn_d%0d", i), 32'(ev_thr), (i < 4) ? 1 : 0);
    end
    rready = 1'b0;
    thr = 7'd0;
    #1;
    chk("thr_zero_empty", 32'(ev_thr), 0);

    // Fill to capacity
    push_n(DEPTH, 0);
    chk("full_wready", 32'(wready_o), 0);
    chk("full_depth", 32'(depth), DEPTH);
    chk("thr_zero_full", 32'(ev_thr), 0);
    thr = 7'd65;
    #1;
    chk("thr_above_depth", 32'(ev_thr), 1);
    wvalid_i = 1'b1;
    wdata_i  = 13'h0FF;
    tick();
    wvalid_i = 1'b0;
    chk("ovf_pulse", 32'(ev_ovf), 1);
    chk("ovf_depth", 32'(depth), DEPTH);
    chk("ovf_head", 32'(head()), 0);
    tick();
    chk("ovf_pulse_end", 32'(ev_ovf), 0);

    // Full, write and read together: write rejected, one pop
    wvalid_i = 1'b1;
    rready   = 1'b1;
    wdata_i  = 13'h1EE;
    tick();
    wvalid_i = 1'b0;
    rready   = 1'b0;
    chk("fullrw_depth", 32'(depth), DEPTH - 1);
    chk("fullrw_ovf", 32'(ev_ovf), 1);
    chk("fullrw_head", 32'(head()), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_depth", 32'(depth), 0);
    chk("clr_ovf", 32'(ev_ovf), 0);

    // Streaming across pointer wrap at depth 1
    wvalid_i = 1'b1;
    wdata_i  = 13'h1000;
    tick();
    rready = 1'b1;
    for (int i = 1; i < 200; i++) begin
      chk("stream_head", 32'(head()), 32'(13'((i - 1) * 37 + 13'h1000)));
      wdata_i = 13'(i * 37 + 13'h1000);
      tick();
      chk("stream_depth", 32'(depth), 1);
      chk("stream_ovf", 32'(ev_ovf), 0);
    end
    wvalid_i = 1'b0;
    chk("stream_last", 32'(head()), 32'(13'(199 * 37 + 13'h1000)));
    tick();
    rready = 1'b0;
    chk("stream_drained", 32'(depth), 0);

    // Clear with simultaneous write at depth 10
    push_n(10, 13'h100);
    chk("pre_clr_depth", 32'(depth), 10);
    clear_i  = 1'b1;
    wvalid_i = 1'b1;
    wdata_i  = 13'h0AA;
    tick();
    clear_i  = 1'b0;
    wvalid_i = 1'b0;
    chk("clrw_depth", 32'(depth), 0);
    chk("clrw_rvalid", 32'(rvalid), 0);
    chk("clrw_ovf", 32'(ev_ovf), 0);

    // Clear while full with a write pending: no overflow event
    push_n(DEPTH, 0);
    clear_i  = 1'b1;
    wvalid_i = 1'b1;
    tick();
    clear_i  = 1'b0;
    wvalid_i = 1'b0;
    chk("clrfull_ovf", 32'(ev_ovf), 0);
    chk("clrfull_depth", 32'(depth), 0);

    // Async reset mid-burst with overflow pulse active
    push_n(DEPTH, 0);
    wvalid_i = 1'b1;
    tick();
    chk("arst_pre_ovf", 32'(ev_ovf), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_depth", 32'(depth), 0);
    chk("arst_rvalid", 32'(rvalid), 0);
    chk("arst_wready", 32'(wready_o), 1);
    chk("arst_ovf", 32'(ev_ovf), 0);
    wvalid_i = 1'b0;
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i3c_fmt_fifo.md
Name: i3c_fmt_fifo

Overview:
Format FIFO that buffers host-mode command entries (one byte plus five control flags) written by the CSR/TTI front end. It presents them to the i3c controller's fmt_fifo_* read interface. The read side is first-word-fall-through and exposes an occupancy count for the controller's read-burst logic. It also raises threshold and overflow events for the interrupt block.

Parameters:
FifoDepth, 64, number of entries; any integer >= 2, not required to be a power of two
FifoDepthWidth, $clog2(FifoDepth+1) (localparam), width of the depth and threshold fields

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
clear_i  input  1  synchronous flush of all entries
wvalid_i  input  1  write request from CSR side
wready_o  output  1  FIFO can accept an entry
wdata_i  input  13  entry: [7:0] byte, [8] start_before, [9] stop_after, [10] read_bytes, [11] read_continue, [12] nak_ok
fmt_fifo_rvalid_o  output  1  head entry is valid
fmt_fifo_rready_i  input  1  controller pops the head entry
fmt_fifo_depth_o  output  FifoDepthWidth  current occupancy
fmt_byte_o  output  8  head byte
fmt_flag_start_before_o  output  1  head flag
fmt_flag_stop_after_o  output  1  head flag
fmt_flag_read_bytes_o  output  1  head flag
fmt_flag_read_continue_o  output  1  head flag
fmt_flag_nak_ok_o  output  1  head flag
fmt_threshold_i  input  FifoDepthWidth  watermark level
event_fmt_threshold_o  output  1  level: depth < threshold
event_fmt_overflow_o  output  1  one-cycle pulse: write attempted while full

Behaviour:
- Reset (rst_i=1, async): write and read pointers are 0 and depth is 0.
  - Reset values: wready_o=1, fmt_fifo_rvalid_o=0, fmt_fifo_depth_o=0, event_fmt_overflow_o=0.
  - event_fmt_threshold_o reflects (0 < fmt_threshold_i) combinationally.
  - Head data outputs are don't-care while rvalid=0; implementation drives them from storage, and the storage array is not reset.
- Write accepted when wvalid_i & wready_o. Entry is stored at wptr on the clock edge.
- wready_o = (depth != FifoDepth). It does not depend on fmt_fifo_rready_i; there is no pass-through when full.
- Read accepted when fmt_fifo_rvalid_o & fmt_fifo_rready_i; rptr advances on that edge.
- fmt_fifo_rvalid_o = (depth != 0).
- Head outputs are combinational from storage[rptr] (FWFT).
- Write-to-rvalid latency is 1 cycle. An entry written at edge N is visible after edge N.
- Simultaneous accepted write and read: depth unchanged, both pointers advance.
- Write into an empty FIFO with rready_i=1 in the same cycle: no read occurs, because rvalid=0 in that cycle.
- Pointers wrap from FifoDepth-1 to 0 (explicit compare, not power-of-two masking).
- depth is a registered counter of FifoDepthWidth bits:
  - +1 on write only, -1 on read only, otherwise unchanged.
  - It never exceeds FifoDepth or goes below 0.
- Overflow:
  - wvalid_i & full: entry dropped, no state change.
  - event_fmt_overflow_o pulses for exactly one cycle, registered: it asserts the cycle after the attempt.
  - Sustained wvalid while full gives one pulse per cycle of attempt.
- Underflow: rready_i while empty is ignored; no event.
- Threshold: event_fmt_threshold_o = (fmt_fifo_depth_o < fmt_threshold_i), combinational.
  - Threshold 0 means never asserted.
  - Threshold > FifoDepth means always asserted.
- clear_i = 1:
  - On the next edge, pointers and depth go to 0 and the overflow pulse register clears.
  - clear_i overrides any simultaneous write or read; the write is dropped and no overflow event is raised.
- Reset mid-operation: all content is lost; outputs return to reset values immediately (async).

Decomposition:
- Shared package (i2c_pkg):
  - FMT_FIFO_WIDTH = 13.
  - Packed struct fmt_entry_t {nak_ok, read_continue, read_bytes, stop_after, start_before, byte[7:0]} matching the wdata_i bit order.
- One sub-module: i3c_sync_fifo.
  - Parameters: Width, Depth.
  - Generic FWFT ring buffer with clr_i, depth_o, wready/rvalid.
  - i3c_fmt_fifo adds field unpacking, the threshold comparator and overflow event registration.

Test Plan:
1. Reset, then write 3 entries {0xA5, start_before=1}, {0x3C}, {0x7E, stop_after=1}, rready=0.
   - Required: depth reads 1,2,3 on successive cycles and rvalid rises 1 cycle after the first write.
   - Then pop 3: outputs 0xA5/start_before=1, 0x3C, 0x7E/stop_after=1 in order; depth returns to 0; rvalid=0.
2. Fill FifoDepth=64 entries.
   - Required: wready=0 and depth=64.
   - A 65th write: one overflow pulse next cycle, depth stays 64, and head is still entry 0.
3. Full FIFO, wvalid=1 and rready=1 in the same cycle.
   - Required: write rejected, one entry popped, depth=63, overflow pulse=1.
4. Stream 200 entries with a concurrent read every cycle after the first write.
   - Required: depth constant at 1, data matches across pointer wrap, no overflow.
5. fmt_threshold_i=4 with depth stepped 0→5→0.
   - Required: event_fmt_threshold_o=1 for depth 0..3 and 0 for depth 4..5.
   - Threshold=0: event never asserted.
6. depth=10, clear_i=1 together with wvalid=1.
   - Required: next cycle depth=0, rvalid=0, no overflow.
   - Assert rst_i asynchronously mid-burst: outputs reach reset values before the next clock edge.
